// File: rtl/avfs_transition_seq_if.sv
// Request, regulator, clock-select and register-bus signals of the AVFS transition sequencer.
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both high;
// req_level must stay stable while req_valid is high, and req_ready never depends on req_valid.
interface avfs_transition_seq_if #(
    parameter int LEVEL_W = 4
);
    logic               req_valid;
    logic [LEVEL_W-1:0] req_level;
    logic               req_ready;
    logic [LEVEL_W-1:0] vreg_level;
    logic               vreg_ack;
    logic [LEVEL_W-1:0] freq_sel;
    logic               busy;
    logic               done;
    logic               err;
    logic               apb_sel;
    logic               apb_we;
    logic [7:0]         apb_addr;
    logic [31:0]        apb_wdata;
    logic [31:0]        apb_rdata;

    modport master (
        output req_valid, req_level, vreg_ack, apb_sel, apb_we, apb_addr, apb_wdata,
        input  req_ready, vreg_level, freq_sel, busy, done, err, apb_rdata
    );

    modport slave (
        input  req_valid, req_level, vreg_ack, apb_sel, apb_we, apb_addr, apb_wdata,
        output req_ready, vreg_level, freq_sel, busy, done, err, apb_rdata
    );
endinterface

// File: rtl/avfs_transition_seq.sv
// Orders regulator and clock-select updates so frequency never runs ahead of voltage:
// voltage first when raising, frequency first when lowering, with settle and ack-timeout timing.
module avfs_transition_seq #(
    parameter int LEVEL_W     = 4,
    parameter int MAX_LEVEL   = 15,
    parameter int DEF_SETTLE  = 64,
    parameter int DEF_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    avfs_transition_seq_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] V_RAISE  = 3'd1;
    localparam logic [2:0] V_SETTLE = 3'd2;
    localparam logic [2:0] F_SET    = 3'd3;
    localparam logic [2:0] F_HOLD   = 3'd4;
    localparam logic [2:0] V_LOWER  = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]         state;
    logic               enable;
    logic [15:0]        settle;
    logic [15:0]        ack_timeout;
    logic [15:0]        cnt;
    logic               err_q;
    logic [LEVEL_W-1:0] cur_level;
    logic [LEVEL_W-1:0] tgt_level;
    logic [LEVEL_W-1:0] vreg_q;
    logic [LEVEL_W-1:0] freq_q;
    logic [LEVEL_W-1:0] req_clamped;
    logic               reg_wr;
    logic               err_clr;
    logic               accept;
    logic               ack_wait;
    logic               timeout_hit;
    logic [15:0]        settle_ld;
    logic [15:0]        timeout_ld;
    logic               unused_wdata;

    assign req_clamped = (bus.req_level > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : bus.req_level;
    assign reg_wr      = bus.apb_sel & bus.apb_we;
    assign err_clr     = reg_wr && (bus.apb_addr == 8'h00) && bus.apb_wdata[1];
    assign accept      = bus.req_valid && bus.req_ready;
    assign ack_wait    = (state == V_RAISE) || (state == V_LOWER);
    // An ack in the final wait cycle wins over the timeout.
    assign timeout_hit = ack_wait && !bus.vreg_ack && (cnt == 16'd0);

    // Counters run down to zero; a zero register still gives one cycle.
    assign settle_ld   = (settle == 16'd0) ? 16'd0 : settle - 16'd1;
    assign timeout_ld  = (ack_timeout == 16'd0) ? 16'd0 : ack_timeout - 16'd1;

    assign bus.req_ready  = enable && (state == IDLE);
    assign bus.vreg_level = vreg_q;
    assign bus.freq_sel   = freq_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err        = err_q;
    assign unused_wdata   = ^bus.apb_wdata[31:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable      <= 1'b0;
            settle      <= 16'(DEF_SETTLE);
            ack_timeout <= 16'(DEF_TIMEOUT);
        end else if (reg_wr) begin
            case (bus.apb_addr)
                8'h00:   enable      <= bus.apb_wdata[0];
                8'h04:   settle      <= bus.apb_wdata[15:0];
                8'h08:   ack_timeout <= bus.apb_wdata[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            cur_level <= '0;
            tgt_level <= '0;
            vreg_q    <= '0;
            freq_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt_level <= req_clamped;
                        if (req_clamped == cur_level) begin
                            state <= DONE;
                        end else if (req_clamped > cur_level) begin
                            state  <= V_RAISE;
                            vreg_q <= req_clamped;
                            cnt    <= timeout_ld;
                        end else begin
                            state  <= F_SET;
                            freq_q <= req_clamped;
                        end
                    end
                end
                V_RAISE: begin
                    if (bus.vreg_ack) begin
                        state <= V_SETTLE;
                        cnt   <= settle_ld;
                    end else if (cnt == 16'd0) begin
                        state  <= DONE;
                        vreg_q <= cur_level;
                        freq_q <= cur_level;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                V_SETTLE: begin
                    if (cnt == 16'd0) begin
                        state  <= F_SET;
                        freq_q <= tgt_level;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                F_SET: begin
                    // cur_level still holds the old level, so this tells the two paths apart.
                    if (tgt_level > cur_level) begin
                        state     <= DONE;
                        cur_level <= tgt_level;
                    end else begin
                        state <= F_HOLD;
                        cnt   <= settle_ld;
                    end
                end
                F_HOLD: begin
                    if (cnt == 16'd0) begin
                        state  <= V_LOWER;
                        vreg_q <= tgt_level;
                        cnt    <= timeout_ld;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                V_LOWER: begin
                    if (bus.vreg_ack) begin
                        state     <= DONE;
                        cur_level <= tgt_level;
                    end else if (cnt == 16'd0) begin
                        state  <= DONE;
                        vreg_q <= cur_level;
                        freq_q <= cur_level;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.apb_rdata = 32'd0;
        if (bus.apb_sel && !bus.apb_we) begin
            case (bus.apb_addr)
                8'h00:   bus.apb_rdata = {31'd0, enable};
                8'h04:   bus.apb_rdata = {16'd0, settle};
                8'h08:   bus.apb_rdata = {16'd0, ack_timeout};
                8'h0C:   bus.apb_rdata = {19'd0, state, err_q, bus.busy, 4'(tgt_level), 4'(cur_level)};
                default: bus.apb_rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_avfs_transition_seq.sv
// Bench for avfs_transition_seq: directed scenarios plus random requests, compared against
// a per-transition timeline computed from the level-ordering and timing rules.
module tb_avfs_transition_seq;
    localparam int LW   = 4;
    localparam int MAXL = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avfs_transition_seq_if #(.LEVEL_W(LW)) bus ();

    avfs_transition_seq #(
        .LEVEL_W(LW), .MAX_LEVEL(MAXL), .DEF_SETTLE(64), .DEF_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cur, m_tgt, m_err, m_en, m_settle, m_timeout;

    // Expected per-cycle outputs: {busy, done, ready, err, freq_sel, vreg_level}
    logic [11:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check_eq("freq_le_vreg", 32'(bus.freq_sel <= bus.vreg_level), 32'd1);
    end

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_err = 0; m_en = 0; m_settle = 64; m_timeout = 1024;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.apb_sel = 1'b1; bus.apb_we = 1'b1; bus.apb_addr = addr; bus.apb_wdata = data;
        @(negedge clk);
        bus.apb_sel = 1'b0; bus.apb_we = 1'b0;
    endtask

    task automatic apb_peek(input logic [7:0] addr, output logic [31:0] data);
        bus.apb_sel = 1'b1; bus.apb_we = 1'b0; bus.apb_addr = addr;
        #1;
        data = bus.apb_rdata;
        bus.apb_sel = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        apb_peek(addr, data);
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
        apb_write(addr, data);
        case (addr)
            8'h00: begin m_en = int'(data[0]); if (data[1]) m_err = 0; end
            8'h04: m_settle  = int'(data[15:0]);
            8'h08: m_timeout = int'(data[15:0]);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_status();
        return 32'((m_err << 9) | (m_tgt << 4) | m_cur);
    endfunction

    // ack_a: cycles into the ack-wait phase at which vreg_ack pulses; negative means never.
    task automatic do_req(input int level, input int ack_a, input bit hammer);
        int tgt, s, t, done_c, ack_c, v, f, e;
        bit ok, raise, lower;
        logic [11:0] w;
        logic [31:0] rd;
        s = (m_settle == 0) ? 1 : m_settle;
        t = (m_timeout == 0) ? 1 : m_timeout;
        tgt   = (level > MAXL) ? MAXL : level;
        raise = tgt > m_cur;
        lower = tgt < m_cur;
        ok    = (ack_a >= 0) && (ack_a < t);
        if (!raise && !lower) begin
            done_c = 1; ack_c = 1; ok = 1;
        end else if (raise) begin
            ack_c  = 1 + ack_a;
            done_c = ok ? 3 + ack_a + s : t + 1;
        end else begin
            ack_c  = 2 + s + ack_a;
            done_c = ok ? 3 + s + ack_a : 2 + s + t;
        end
        if (ack_a < 0) ack_c = -1;

        exp_q.delete();
        for (int n = 1; n <= done_c + 1; n++) begin
            v = m_cur; f = m_cur;
            if (raise && ok) begin
                v = tgt;
                f = (n >= 2 + ack_a + s) ? tgt : m_cur;
            end else if (raise) begin
                v = (n < done_c) ? tgt : m_cur;
            end else if (lower && ok) begin
                f = tgt;
                v = (n >= 2 + s) ? tgt : m_cur;
            end else if (lower) begin
                f = (n < done_c) ? tgt : m_cur;
                v = (n >= 2 + s && n < done_c) ? tgt : m_cur;
            end
            e = (!ok && n >= done_c) ? 1 : m_err;
            w = {1'(n <= done_c), 1'(n == done_c), 1'(n > done_c ? m_en : 0), 1'(e), 4'(f), 4'(v)};
            exp_q.push_back(w);
        end

        @(negedge clk);
        check_eq("ready_pre", 32'(bus.req_ready), 32'(m_en));
        bus.req_valid = 1'b1;
        bus.req_level = 4'(level);
        for (int n = 1; n <= done_c + 1; n++) begin
            @(negedge clk);
            bus.vreg_ack = 1'b0;
            w = exp_q.pop_front();
            check_eq("busy",  32'(bus.busy),       32'(w[11]));
            check_eq("done",  32'(bus.done),       32'(w[10]));
            check_eq("ready", 32'(bus.req_ready),  32'(w[9]));
            check_eq("err",   32'(bus.err),        32'(w[8]));
            check_eq("freq",  32'(bus.freq_sel),   32'(w[7:4]));
            check_eq("vreg",  32'(bus.vreg_level), 32'(w[3:0]));
            bus.req_valid = hammer && (n < done_c);
            bus.req_level = 4'($urandom_range(0, 15));
            if (n == ack_c) bus.vreg_ack = 1'b1;
        end
        bus.req_valid = 1'b0;
        bus.vreg_ack  = 1'b0;
        m_tgt = tgt;
        if (ok) m_cur = tgt;
        else    m_err = 1;
        apb_read(8'h0C, rd);
        check_eq("status", rd, exp_status());
    endtask

    task automatic blocked_req();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_level = 4'($urandom_range(0, 15));
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_eq("blk_ready", 32'(bus.req_ready), 32'd0);
            check_eq("blk_busy",  32'(bus.busy),      32'd0);
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int t, a;
        bus.req_valid = 1'b0; bus.req_level = '0; bus.vreg_ack = 1'b0;
        bus.apb_sel = 1'b0; bus.apb_we = 1'b0; bus.apb_addr = '0; bus.apb_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_vreg",  32'(bus.vreg_level), 32'd0);
        check_eq("rst_freq",  32'(bus.freq_sel),   32'd0);
        check_eq("rst_busy",  32'(bus.busy),       32'd0);
        check_eq("rst_done",  32'(bus.done),       32'd0);
        check_eq("rst_err",   32'(bus.err),        32'd0);
        check_eq("rst_ready", 32'(bus.req_ready),  32'd0);
        check_eq("rst_rdata_idle", bus.apb_rdata, 32'd0);
        apb_read(8'h0C, rd); check_eq("rst_status",  rd, 32'h000);
        apb_read(8'h00, rd); check_eq("rst_ctrl",    rd, 32'd0);
        apb_read(8'h04, rd); check_eq("rst_settle",  rd, 32'd64);
        apb_read(8'h08, rd); check_eq("rst_timeout", rd, 32'd1024);

        // Raise 0->5 with ack 3 cycles after the regulator command
        reg_write(8'h00, 32'h1);
        reg_write(8'h04, 32'd4);
        do_req(5, 3, 1'b0);

        // Lower 5->2 with busy-time request hammering
        do_req(2, 1, 1'b1);

        // Raise with no ack: timeout abort, then ERR_CLR
        reg_write(8'h08, 32'd8);
        do_req(9, -1, 1'b0);
        reg_write(8'h00, 32'h3);
        check_eq("err_cleared", 32'(bus.err), 32'd0);
        apb_read(8'h00, rd); check_eq("ctrl_errclr_reads0", rd, 32'd1);

        // Same level with a stray ack, then clamped request with ack on the timeout cycle
        do_req(2, 0, 1'b0);
        do_req(15, 7, 1'b0);

        // Read-only and unmapped writes are ignored
        apb_write(8'h0C, 32'hFFFF_FFFF);
        apb_read(8'h0C, rd); check_eq("status_ro", rd, exp_status());
        apb_write(8'h20, 32'h5);
        apb_read(8'h20, rd); check_eq("unmapped", rd, 32'd0);
        apb_read(8'h04, rd); check_eq("settle_rb", rd, 32'd4);
        apb_read(8'h08, rd); check_eq("timeout_rb", rd, 32'd8);

        // SETTLE=0 behaves as one cycle
        reg_write(8'h04, 32'd0);
        do_req(3, 0, 1'b1);

        // Randomized transitions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) reg_write(8'h04, 32'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) reg_write(8'h08, 32'($urandom_range(0, 9)));
            if (m_err != 0 && $urandom_range(0, 2) == 0) reg_write(8'h00, 32'h3);
            if ($urandom_range(0, 7) == 0) begin
                reg_write(8'h00, 32'h0);
                blocked_req();
                reg_write(8'h00, 32'h1);
            end
            t = (m_timeout == 0) ? 1 : m_timeout;
            a = int'($urandom_range(0, t + 2)) - 1;
            do_req(int'($urandom_range(0, 15)), a, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during V_SETTLE
        reg_write(8'h04, 32'd4);
        reg_write(8'h08, 32'd20);
        do_req(0, 0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_level = 4'd6;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.vreg_ack = 1'b1;
        @(negedge clk);
        bus.vreg_ack = 1'b0;
        check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
        check_eq("pre_rst_vreg", 32'(bus.vreg_level), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_vreg", 32'(bus.vreg_level), 32'd0);
        check_eq("arst_freq", 32'(bus.freq_sel),   32'd0);
        check_eq("arst_busy", 32'(bus.busy),       32'd0);
        check_eq("arst_done", 32'(bus.done),       32'd0);
        apb_peek(8'h0C, rd); check_eq("arst_status", rd, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apb_read(8'h00, rd); check_eq("post_rst_ctrl", rd, 32'd0);
        check_eq("post_rst_ready", 32'(bus.req_ready), 32'd0);
        apb_read(8'h04, rd); check_eq("post_rst_settle", rd, 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avfs_transition_seq.md
Name: avfs_transition_seq

Overview:
Sequences voltage/frequency level changes for the AVFS domain so that voltage and frequency never reach an unsafe pairing. The block accepts a target level from the AVFS policy logic. It then drives the regulator level and freq_sel in a safe order:
- Raising the level: voltage changes first, then frequency.
- Lowering the level: frequency changes first, then voltage.
Settle time and regulator-ack timeout are programmed over the same APB-style register bus used by avfs_controller.

Parameters:
LEVEL_W, 4, width of level codes on req_level, vreg_level and freq_sel
MAX_LEVEL, 15, highest legal level; requests above this are clamped to MAX_LEVEL
DEF_SETTLE, 64, reset value of SETTLE register, in clk cycles
DEF_TIMEOUT, 1024, reset value of ACK_TIMEOUT register, in clk cycles

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  target-level request valid
req_level  in  LEVEL_W  requested target level
req_ready  out  1  sequencer can accept a request
vreg_level  out  LEVEL_W  voltage level command to regulator
vreg_ack  in  1  regulator reports it has reached vreg_level (single-cycle pulse)
freq_sel  out  LEVEL_W  clock frequency select
busy  out  1  transition in progress
done  out  1  one-cycle pulse when a transition completes or aborts
err  out  1  sticky regulator-timeout flag
apb_sel  in  1  register access select
apb_we  in  1  1 = write, 0 = read
apb_addr  in  8  byte address
apb_wdata  in  32  write data
apb_rdata  out  32  read data

Behaviour:
- Reset values: vreg_level=0, freq_sel=0, cur_level=0, busy=0, done=0, err=0, req_ready=0 (while ENABLE=0), apb_rdata=0.
- State machine states: IDLE, V_RAISE, V_SETTLE, F_SET, F_HOLD, V_LOWER, DONE.
- Registers:
  - 0x00 CTRL: bit0 ENABLE (reset 0); bit1 ERR_CLR (write 1 clears err, self-clearing, reads 0).
  - 0x04 SETTLE[15:0].
  - 0x08 ACK_TIMEOUT[15:0].
  - 0x0C STATUS, read-only: [3:0] cur_level, [7:4] tgt_level, [8] busy, [9] err, [12:10] state encoding IDLE=0 … DONE=6.
- Register writes take effect at posedge clk when apb_sel & apb_we. Writes to 0x0C and to unmapped addresses are ignored.
- apb_rdata is combinational: the register value when apb_sel & ~apb_we, otherwise 0. Unmapped reads return 0.
- req_ready = ENABLE & (state==IDLE). A request is accepted on req_valid & req_ready; tgt_level = min(req_level, MAX_LEVEL) is latched.
- IDLE transitions on accept:
  - tgt==cur_level: go to DONE directly; no output change.
  - tgt>cur: go to V_RAISE.
  - tgt<cur: go to F_SET.
- Raise path:
  - V_RAISE: vreg_level=tgt; wait for vreg_ack with timeout counter.
  - On ack, go to V_SETTLE: count max(SETTLE,1) cycles.
  - F_SET: freq_sel=tgt.
  - DONE: cur_level=tgt.
- Lower path:
  - F_SET: freq_sel=tgt.
  - F_HOLD: count max(SETTLE,1) cycles.
  - V_LOWER: vreg_level=tgt; wait for vreg_ack with timeout counter.
  - DONE: cur_level=tgt.
- Timeout: the ack-wait counter starts at 0 on entry to V_RAISE or V_LOWER. Reaching max(ACK_TIMEOUT,1) without vreg_ack triggers an abort:
  - vreg_level reverts to cur_level.
  - On the lower path, freq_sel also reverts to cur_level.
  - err is set; state goes to DONE; cur_level is unchanged.
  - vreg_ack arriving in the same cycle as the timeout counts as success.
- vreg_ack outside V_RAISE/V_LOWER is ignored.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy=1 in every state except IDLE.
- Clearing ENABLE mid-transition does not abort the transition; it only blocks new requests.
- Register changes to SETTLE/ACK_TIMEOUT mid-transition take effect on the next counter start.
- ERR_CLR in the same cycle as a new timeout: err stays set.
- Asynchronous reset mid-transition returns all state and outputs to their reset values immediately.
- Invariant, checked by the bench: freq_sel <= vreg_level at every cycle outside reset.

Test Plan:
- Reset, then read STATUS and CTRL → STATUS=0x000, CTRL=0, SETTLE=64, ACK_TIMEOUT=1024; req_ready=0 with ENABLE=0.
- Write CTRL=1, SETTLE=4; request level 5; vreg_ack 3 cycles after vreg_level=5 → freq_sel changes to 5 exactly 4 cycles after the ack cycle; done pulses once; STATUS[3:0]=5.
- From level 5, request level 2 → freq_sel=2 in the cycle after accept while vreg_level is still 5; after 4 hold cycles vreg_level=2; ack → done; cur_level=2.
- ACK_TIMEOUT=8; request level 9; never assert vreg_ack → after 8 cycles vreg_level returns to 2, freq_sel stays 2, err=1, done pulses; write CTRL=0x3 → err=0.
- Request level 2 while cur_level=2 → done pulse 1 cycle after accept; no change on vreg_level or freq_sel. Request level while busy → req_ready=0 and the request is not accepted. Request 0xF with MAX_LEVEL=12 → tgt_level=12.
- Assert rst_n=0 during V_SETTLE → vreg_level, freq_sel, busy, cur_level all 0 immediately; CTRL.ENABLE=0 after release.
